bram_arbiter: RTL and testbench

BRAM_ARBITER -- requirements
Module: bram_arbiter

---
 rtl/bram_arbiter.sv | 135 +++++++++++++
 tb/tb_bram_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/bram_arbiter.sv
// Two-requester arbiter in front of a single-port BRAM with a one-cycle read latency.
// Define RR_ARB_EN for round-robin tie-breaking; otherwise requester 0 has fixed priority.
module bram_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_addrs,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_WE,
  output logic              mem_RE,
  input  logic [DATA_W-1:0] mem_q,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  // Handshake: a requester raises req with we/addr/wdata and holds them until
  // it sees its one-cycle ack; a req still high after the ack is a new request.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RWAIT = 2'd2,
    ACK   = 2'd3
  } state_t;

  state_t              state;
  logic                sel;
  logic                lat_we;
  logic                grant1;
  logic                win_we;
  logic [ADDR_W-1:0]   win_addr;
  logic [DATA_W-1:0]   win_data;

`ifdef RR_ARB_EN
  logic last;

  // On a tie, requester 1 wins only if requester 0 was granted last.
  assign grant1 = req1 & (~req0 | ~last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= 1'b1;
    end else if (state == IDLE && (req0 || req1)) begin
      last <= grant1;
    end
  end
`else
  assign grant1 = req1 & ~req0;
`endif

  always_comb begin
    win_we   = we0;
    win_addr = addr0;
    win_data = wdata0;
    if (grant1) begin
      win_we   = we1;
      win_addr = addr1;
      win_data = wdata1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sel       <= 1'b0;
      lat_we    <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
      mem_addrs <= '0;
      mem_data  <= '0;
      mem_WE    <= 1'b0;
      mem_RE    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            sel       <= grant1;
            lat_we    <= win_we;
            mem_addrs <= win_addr;
            mem_data  <= win_data;
            mem_WE    <= win_we;
            mem_RE    <= ~win_we;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          mem_WE <= 1'b0;
          mem_RE <= 1'b0;
          if (lat_we) begin
            ack0  <= ~sel;
            ack1  <= sel;
            state <= ACK;
          end else begin
            state <= RWAIT;
          end
        end
        RWAIT: begin
          // mem_q is valid now, one cycle after the edge that sampled mem_RE.
          if (sel) rdata1 <= mem_q;
          else     rdata0 <= mem_q;
          ack0  <= ~sel;
          ack1  <= sel;
          state <= ACK;
        end
        ACK: begin
          ack0  <= 1'b0;
          ack1  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed bench for bram_arbiter: a BRAM model, a driver, and a monitor that
// pops expected memory operations and acks from scoreboard queues.
module tb_bram_arbiter;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_RWAIT = 2'd2;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1;
  logic [DW-1:0] rdata0, rdata1;
  logic [AW-1:0] mem_addrs;
  logic [DW-1:0] mem_data;
  logic          mem_WE, mem_RE;
  logic [DW-1:0] mem_q;
  logic          busy;
  logic [1:0]    dbg_state;

  int total = 0;
  int bad   = 0;

  // {we, addr, data} of each expected BRAM access, and {port, we, rdata} of each ack
  logic [AW+DW:0] exp_mem_q[$];
  logic [DW+1:0]  exp_ack_q[$];

  bram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .mem_addrs(mem_addrs), .mem_data(mem_data), .mem_WE(mem_WE), .mem_RE(mem_RE),
    .mem_q(mem_q), .busy(busy), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] bram [256];
  always @(posedge clk) begin
    if (mem_WE) bram[mem_addrs] <= mem_data;
    if (mem_RE) mem_q <= bram[mem_addrs];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor
  int            cyc = 0;
  int            issue_cyc = 0;
  logic [DW-1:0] exp_rd0 = '0;
  logic [DW-1:0] exp_rd1 = '0;
  always @(negedge clk) begin
    logic [AW+DW:0] m;
    logic [DW+1:0]  a;
    cyc++;
    chk("we_re_excl", 32'(mem_WE & mem_RE), 32'd0);
    chk("ack_excl", 32'(ack0 & ack1), 32'd0);
    chk("busy_vs_state", 32'(busy), 32'(dbg_state != S_IDLE));
    if (rst) begin
      exp_rd0 = '0;
      exp_rd1 = '0;
    end else begin
      if (mem_WE || mem_RE) begin
        if (exp_mem_q.size() == 0) begin
          chk("mem_op_unexpected", 32'({mem_WE, mem_RE}), 32'd0);
        end else begin
          m = exp_mem_q.pop_front();
          chk("mem_op", 32'({mem_WE, mem_RE, mem_addrs, mem_data}),
              32'({m[AW+DW], ~m[AW+DW], m[AW+DW-1:0]}));
          issue_cyc = cyc;
        end
      end
      if (ack0 || ack1) begin
        if (exp_ack_q.size() == 0) begin
          chk("ack_unexpected", 32'({ack1, ack0}), 32'd0);
        end else begin
          a = exp_ack_q.pop_front();
          chk("ack_port", 32'({ack1, ack0}), a[DW+1] ? 32'd2 : 32'd1);
          chk("ack_latency", 32'(cyc - issue_cyc), a[DW] ? 32'd1 : 32'd2);
          if (!a[DW]) begin
            if (a[DW+1]) exp_rd1 = a[DW-1:0];
            else         exp_rd0 = a[DW-1:0];
          end
        end
      end
      chk("rdata0", 32'(rdata0), 32'(exp_rd0));
      chk("rdata1", 32'(rdata1), 32'(exp_rd1));
    end
  end

  // Driver tasks
  task automatic wait_ack();
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (ack0 || ack1) seen = 1'b1;
    end
    chk("ack_seen", 32'(seen), 32'd1);
  endtask

  task automatic wait_state(input logic [1:0] s);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (dbg_state == s) seen = 1'b1;
    end
    chk("state_reached", 32'(seen), 32'd1);
  endtask

  task automatic drive(input bit port, input bit we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] data);
    if (port) begin
      req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = data;
    end else begin
      req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = data;
    end
  endtask

  task automatic expect_op(input bit port, input bit we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] data, input logic [DW-1:0] rexp);
    exp_mem_q.push_back({we, addr, data});
    exp_ack_q.push_back({port, we, rexp});
  endtask

  task automatic do_access(input bit port, input bit we, input logic [AW-1:0] addr,
                           input logic [DW-1:0] data, input logic [DW-1:0] rexp);
    expect_op(port, we, addr, data, rexp);
    drive(port, we, addr, data);
    wait_ack();
    if (port) req1 = 1'b0;
    else      req0 = 1'b0;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_ctrl", 32'({ack0, ack1, mem_WE, mem_RE, busy}), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(S_IDLE));
    chk("rst_mem_addrs", 32'(mem_addrs), 32'd0);
    chk("rst_mem_data", 32'(mem_data), 32'd0);
    chk("rst_rdata", 32'({rdata0, rdata1}), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    repeat (3) @(negedge clk);
    chk_reset_outputs();
    rst = 1'b0;
    @(negedge clk);

    // Write then read back the top address through the other port
    do_access(1'b0, 1'b1, 8'hFF, 8'hAA, 8'h00);
    @(negedge clk);
    do_access(1'b1, 1'b0, 8'hFF, 8'h00, 8'hAA);
    @(negedge clk);

    // Both requesters held high together
`ifdef RR_ARB_EN
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) expect_op(1'b0, 1'b1, 8'hFA, 8'hBA, 8'h00);
      else            expect_op(1'b1, 1'b1, 8'hFB, 8'hBB, 8'h00);
    end
`else
    for (int k = 0; k < 4; k++) expect_op(1'b0, 1'b1, 8'hFA, 8'hBA, 8'h00);
    expect_op(1'b1, 1'b1, 8'hFB, 8'hBB, 8'h00);
`endif
    drive(1'b0, 1'b1, 8'hFA, 8'hBA);
    drive(1'b1, 1'b1, 8'hFB, 8'hBB);
    repeat (4) wait_ack();
`ifdef RR_ARB_EN
    req0 = 1'b0;
    req1 = 1'b0;
`else
    req0 = 1'b0;
    wait_ack();
    req1 = 1'b0;
`endif
    @(negedge clk);

    // Requester 1 arrives while requester 0 is in ISSUE
    expect_op(1'b0, 1'b1, 8'h10, 8'h55, 8'h00);
    expect_op(1'b1, 1'b0, 8'h10, 8'h00, 8'h55);
    drive(1'b0, 1'b1, 8'h10, 8'h55);
    wait_state(S_ISSUE);
    drive(1'b1, 1'b0, 8'h10, 8'h00);
    wait_ack();
    req0 = 1'b0;
    wait_ack();
    req1 = 1'b0;
    @(negedge clk);

    // Reset lands in RWAIT: the read is dropped, then retried
    exp_mem_q.push_back({1'b0, 8'hFF, 8'h00});
    drive(1'b0, 1'b0, 8'hFF, 8'h00);
    wait_state(S_RWAIT);
    #2 rst = 1'b1;
    #1 chk_reset_outputs();
    req0 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_access(1'b0, 1'b0, 8'hFF, 8'h00, 8'hAA);

    repeat (3) @(negedge clk);
    chk("mem_q_drained", 32'(exp_mem_q.size()), 32'd0);
    chk("ack_q_drained", 32'(exp_ack_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
